// File: rtl/trs80_sd_pkg.sv
// Shared types and constants for the trs80 SD sector scheduler and its helpers.
package trs80_sd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2,
    FIN   = 2'd3
  } sched_state_t;

  localparam int SECT_BYTES_C = 512;

  typedef logic [31:0] lba_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester after 'last' (with wrap) wins.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         grant
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] idx;
  logic          found;

  // scan candidates in priority order starting just after the previous winner
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IW'((int'(last) + i) % N);
      if (req[idx] && !found) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/sd_sector_sched.sv
// Round-robin SD sector scheduler between the FDC virtual drives and the hps_io SD port.
// Optional ISSUE-phase ack timeout is enabled by defining SD_SCHED_TIMEOUT_EN.
module sd_sector_sched
  import trs80_sd_pkg::*;
#(
  parameter int NDRV        = 2,
  parameter int LBA_W       = 32,
  parameter int SECT_BYTES  = SECT_BYTES_C,
  parameter int TIMEOUT_CYC = 2**24
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [NDRV-1:0]         req_valid,
  input  logic [NDRV-1:0]         req_write,
  input  logic [NDRV*LBA_W-1:0]   req_lba,
  output logic [NDRV-1:0]         req_ready,
  output logic [NDRV-1:0]         done,
  output logic [NDRV-1:0]         err,
  input  logic [NDRV-1:0]         img_mounted,
  output lba_t                    sd_lba,
  output logic [NDRV-1:0]         sd_rd,
  output logic [NDRV-1:0]         sd_wr,
  input  logic                    sd_ack,
  input  logic                    sd_buff_wr,
  output logic                    busy,
  output logic [$clog2(NDRV)-1:0] cur_drv
);

  localparam int DW = $clog2(NDRV);
  localparam int CW = $clog2(SECT_BYTES + 1);

  sched_state_t  state;
  logic [NDRV-1:0] grant;
  logic [NDRV-1:0] sel;
  logic [DW-1:0] last_grant;
  logic [DW-1:0] gidx;
  logic [CW-1:0] byte_cnt;
  logic          op_write;
  logic          mount_hit;
  logic          can_grant;
  logic          take;

`ifdef SD_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
`else
  localparam bit unused_timeout_cfg = (TIMEOUT_CYC > 0);
`endif

  rr_arbiter #(.N(NDRV)) u_arb (
    .req   (req_valid),
    .last  (last_grant),
    .grant (grant)
  );

  // A held ack (e.g. after reset mid-transfer) blocks new grants until it falls.
  assign can_grant = (state == IDLE) && !sd_ack && !reset;
  assign take      = |req_ready;

  // acceptance strobe and winner index; a coinciding mount pulse vetoes the grant
  always_comb begin
    req_ready = '0;
    gidx      = '0;
    if (can_grant) begin
      req_ready = grant & ~img_mounted;
    end else begin
      req_ready = '0;
    end
    for (int i = 0; i < NDRV; i++) begin
      if (grant[i]) begin
        gidx = DW'(i);
      end else begin
        gidx = gidx;
      end
    end
  end

  // transfer sequencer with registered HPS and status outputs
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      done       <= '0;
      err        <= '0;
      sd_rd      <= '0;
      sd_wr      <= '0;
      sd_lba     <= '0;
      busy       <= 1'b0;
      cur_drv    <= '0;
      last_grant <= DW'(NDRV - 1);
      byte_cnt   <= '0;
      sel        <= '0;
      op_write   <= 1'b0;
      mount_hit  <= 1'b0;
`ifdef SD_SCHED_TIMEOUT_EN
      tcnt       <= '0;
`endif
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        IDLE: begin
          if (take) begin
            sel        <= grant;
            cur_drv    <= gidx;
            last_grant <= gidx;
            op_write   <= req_write[gidx];
            sd_lba     <= lba_t'(req_lba[int'(gidx)*LBA_W +: LBA_W]);
            sd_rd      <= req_write[gidx] ? '0 : grant;
            sd_wr      <= req_write[gidx] ? grant : '0;
            mount_hit  <= 1'b0;
            busy       <= 1'b1;
            state      <= ISSUE;
`ifdef SD_SCHED_TIMEOUT_EN
            tcnt       <= '0;
`endif
          end else if (can_grant) begin
            err <= grant & img_mounted;
          end
        end
        ISSUE: begin
          mount_hit <= mount_hit | (|(img_mounted & sel));
          if (sd_ack) begin
            sd_rd <= '0;
            sd_wr <= '0;
            state <= XFER;
          end
`ifdef SD_SCHED_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            sd_rd <= '0;
            sd_wr <= '0;
            err   <= sel;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
`endif
        end
        XFER: begin
          mount_hit <= mount_hit | (|(img_mounted & sel));
          if (sd_buff_wr && (byte_cnt != CW'(SECT_BYTES))) begin
            byte_cnt <= byte_cnt + CW'(1);
          end
          if (!sd_ack) begin
            state <= FIN;
          end
        end
        FIN: begin
          if (mount_hit || (|(img_mounted & sel)) ||
              (!op_write && (byte_cnt != CW'(SECT_BYTES)))) begin
            err <= sel;
          end else begin
            done <= sel;
          end
          byte_cnt <= '0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
